// File: rtl/vga_scanout.sv
// vga_scanout: prefetches framebuffer lines into a two-bank line buffer over a
// request/grant read port and emits RGB332 pixels with sync and DE delayed by
// two cycles. Missing line data is shown as UNDERRUN_COLOR and flagged sticky.
//
// Fetch FSM states:
//   state   | meaning
//   IDLE    | no transaction; waits until the next line may be fetched
//   REQ     | mem_req_o held with a stable address until granted
//   WAIT    | one read outstanding; waiting for mem_rvalid_i
module vga_scanout #(
  parameter int          H_RES          = 640,
  parameter int          V_RES          = 480,
  parameter logic [31:0] FB_BASE        = 32'h0000_0000,
  parameter logic [7:0]  UNDERRUN_COLOR = 8'hE0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  x_i,
  input  logic [9:0]  y_i,
  input  logic        active_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic [7:0]  rgb_o,
  output logic        de_o,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        underrun_o
);

  localparam int          WPL       = H_RES / 4;
  localparam int          AW        = (WPL > 1) ? $clog2(WPL) : 1;
  localparam logic [7:0]  LAST_WORD = 8'(WPL - 1);
  localparam logic [31:0] WPL_W     = 32'(WPL);
  localparam logic [9:0]  V_RES_L   = 10'(V_RES);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} fetch_state_e;

  fetch_state_e state, state_nx;

  logic        vsync_q, active_q;
  logic        fs, eol;
  logic        armed, restart;
  logic [9:0]  disp_line, fetch_line;
  logic [1:0]  ready, ready_nx;
  logic [7:0]  word;
  logic        eligible, rvalid_take, drop, wr_en, last_word;
  logic [31:0] line_base;

  logic [31:0] bank0 [WPL];
  logic [31:0] bank1 [WPL];
  logic [31:0] rd_word;
  logic [AW-1:0] rd_idx, wr_idx;

  logic [1:0]  xsel;
  logic        de1, hs1, vs1, uf1;
  logic [7:0]  pix;

  // y_i only mirrors the internal line count, upper x_i bits index past the buffer
  logic unused_inputs;
  assign unused_inputs = ^{y_i, x_i};

  assign fs  = vsync_q & ~vsync_i;
  assign eol = active_q & ~active_i;

  // Event qualification and datapath control terms
  always_comb begin
    eligible    = armed && (fetch_line < V_RES_L)
                  && ({1'b0, fetch_line} <= ({1'b0, disp_line} + 11'd1))
                  && !restart && !fs;
    line_base   = FB_BASE + ((32'(fetch_line) * WPL_W) << 2);
    rvalid_take = (state == ST_WAIT) && mem_rvalid_i;
    // A frame start in the same cycle as a response discards it too.
    drop        = restart || fs;
    wr_en       = rvalid_take && !drop;
    last_word   = (word == LAST_WORD);
    wr_idx      = word[AW-1:0];
    rd_idx      = x_i[AW+1:2];
  end

  // Fetch FSM next-state and request output
  always_comb begin
    state_nx  = state;
    mem_req_o = 1'b0;
    case (state)
      ST_IDLE: if (eligible) state_nx = ST_REQ;
      ST_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid_i) begin
          if (drop || last_word) state_nx = ST_IDLE;
          else                   state_nx = ST_REQ;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Ready flags: fill sets, end of line clears the displayed bank, frame start clears both
  always_comb begin
    ready_nx = ready;
    if (wr_en && last_word) ready_nx[fetch_line[0]] = 1'b1;
    if (eol)                ready_nx[disp_line[0]]  = 1'b0;
    if (fs)                 ready_nx                = 2'b00;
  end

  // Fetch FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Edge detect, line counters, fetch address/word and control flags
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vsync_q    <= 1'b1;
      active_q   <= 1'b0;
      armed      <= 1'b0;
      restart    <= 1'b0;
      disp_line  <= '0;
      fetch_line <= '0;
      ready      <= '0;
      word       <= '0;
      mem_addr_o <= '0;
    end else begin
      vsync_q  <= vsync_i;
      active_q <= active_i;
      ready    <= ready_nx;
      if (fs) armed <= 1'b1;

      if (fs)       disp_line <= '0;
      else if (eol) disp_line <= disp_line + 10'd1;

      if (fs)                         fetch_line <= '0;
      else if (wr_en && last_word)    fetch_line <= fetch_line + 10'd1;

      if (rvalid_take && drop)             restart <= 1'b0;
      else if (fs && (state != ST_IDLE))   restart <= 1'b1;

      if ((state == ST_IDLE) && eligible) begin
        word       <= '0;
        mem_addr_o <= line_base;
      end else if (wr_en && !last_word) begin
        word       <= word + 8'd1;
        mem_addr_o <= mem_addr_o + 32'd4;
      end
    end
  end

  // Line buffer: fetch writes, display reads synchronously
  always_ff @(posedge clk_i) begin
    if (wr_en && !fetch_line[0]) bank0[wr_idx] <= mem_rdata_i;
    if (wr_en &&  fetch_line[0]) bank1[wr_idx] <= mem_rdata_i;
    rd_word <= disp_line[0] ? bank1[rd_idx] : bank0[rd_idx];
  end

  // S1: capture controls alongside the buffer read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xsel <= '0;
      de1  <= 1'b0;
      hs1  <= 1'b1;
      vs1  <= 1'b1;
      uf1  <= 1'b0;
    end else begin
      xsel <= x_i[1:0];
      de1  <= active_i;
      hs1  <= hsync_i;
      vs1  <= vsync_i;
      uf1  <= armed && active_i && !ready[disp_line[0]];
    end
  end

  // Byte select within the fetched word
  always_comb begin
    pix = rd_word[7:0];
    case (xsel)
      2'd1:    pix = rd_word[15:8];
      2'd2:    pix = rd_word[23:16];
      2'd3:    pix = rd_word[31:24];
      default: pix = rd_word[7:0];
    endcase
  end

  // S2: output registers and sticky underrun
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rgb_o      <= '0;
      de_o       <= 1'b0;
      hsync_o    <= 1'b1;
      vsync_o    <= 1'b1;
      underrun_o <= 1'b0;
    end else begin
      rgb_o      <= !de1 ? 8'h00 : (uf1 ? UNDERRUN_COLOR : pix);
      de_o       <= de1;
      hsync_o    <= hs1;
      vsync_o    <= vs1;
      if (uf1) underrun_o <= 1'b1;
    end
  end

endmodule
